// File: rtl/mo_gemm.sv
// mo_gemm: Y = A*X (+/-) B engine driving a request/ready matrix-memory bus (opcode/i/j).
// Define MO_GEMM_SAT_EN for saturating accumulation and +/- b instead of modular wrap.
module mo_gemm #(
    parameter int unsigned DW = 10,
    parameter int unsigned IW = 10,
    parameter int unsigned AW = 2*DW+IW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          mem_ready,
    input  logic [1:0]    mode,
    output logic [2:0]    opcode,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [AW-1:0] out_data,
    output logic          fin
);
    localparam int unsigned PW = 2*DW;
`ifdef MO_GEMM_SAT_EN
    localparam int unsigned SW = ((AW > PW) ? AW : PW) + 1;
    localparam logic [AW-1:0] ACC_MAX = {AW{1'b1}};
`endif

    localparam logic [3:0] S_INIT    = 4'd0;
    localparam logic [3:0] S_GET_N   = 4'd1;
    localparam logic [3:0] S_GET_R   = 4'd2;
    localparam logic [3:0] S_GET_M   = 4'd3;
    localparam logic [3:0] S_READ_A  = 4'd4;
    localparam logic [3:0] S_READ_X  = 4'd5;
    localparam logic [3:0] S_READ_B  = 4'd6;
    localparam logic [3:0] S_WRITE_Y = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    localparam logic [1:0] M_ADD = 2'b00;
    localparam logic [1:0] M_SUB = 2'b01;
    localparam logic [1:0] M_NOB = 2'b10;

    logic [3:0]    state_q, state_d, elem_start;
    logic [IW-1:0] n_q, n_d, r_q, r_d, m_q, m_d;
    logic [IW-1:0] row_q, row_d, col_q, col_d, k_q, k_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [2:0]    opcode_d;
    logic [IW-1:0] i_d, j_d;
    logic [AW-1:0] out_d;
    logic          fin_d;
    logic [IW-1:0] dim_in;
    logic [PW-1:0] prod;

    assign dim_in = IW'(in_data);
    assign prod   = PW'(a_q) * PW'(in_data);

    // Accumulate one product into acc
    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] acc, input logic [PW-1:0] p);
`ifdef MO_GEMM_SAT_EN
        logic [SW-1:0] s;
        s = SW'(acc) + SW'(p);
        return (s > SW'(ACC_MAX)) ? ACC_MAX : AW'(s);
`else
        return acc + AW'(p);
`endif
    endfunction

    // Final Y element from acc, b and the latched mode
    function automatic logic [AW-1:0] y_value(input logic [AW-1:0] acc, input logic [DW-1:0] b,
                                              input logic [1:0] md);
        logic [AW-1:0] y;
`ifdef MO_GEMM_SAT_EN
        logic [SW-1:0] s;
        s = SW'(acc) + SW'(b);
        case (md)
            M_SUB:   y = (SW'(b) > SW'(acc)) ? '0 : AW'(SW'(acc) - SW'(b));
            M_NOB:   y = acc;
            default: y = (s > SW'(ACC_MAX)) ? ACC_MAX : AW'(s);
        endcase
`else
        case (md)
            M_SUB:   y = acc - AW'(b);
            M_NOB:   y = acc;
            default: y = acc + AW'(b);
        endcase
`endif
        return y;
    endfunction

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        r_d     = r_q;
        m_d     = m_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        elem_start = (r_q == '0) ? ((mode_q == M_NOB) ? S_WRITE_Y : S_READ_B) : S_READ_A;

        case (state_q)
            S_INIT:  state_d = S_GET_N;
            S_GET_N: if (mem_ready) begin
                n_d     = dim_in;
                mode_d  = (mode == 2'b11) ? M_ADD : mode;
                state_d = S_GET_R;
            end
            S_GET_R: if (mem_ready) begin
                r_d     = dim_in;
                state_d = S_GET_M;
            end
            S_GET_M: if (mem_ready) begin
                m_d     = dim_in;
                state_d = (n_q == '0 || dim_in == '0) ? S_DONE : elem_start;
            end
            S_READ_A: if (mem_ready) begin
                a_d     = in_data;
                state_d = S_READ_X;
            end
            S_READ_X: if (mem_ready) begin
                acc_d = acc_add(acc_q, prod);
                if (k_q == r_q - IW'(1)) begin
                    k_d     = '0;
                    state_d = (mode_q == M_NOB) ? S_WRITE_Y : S_READ_B;
                end else begin
                    k_d     = k_q + IW'(1);
                    state_d = S_READ_A;
                end
            end
            S_READ_B: if (mem_ready) begin
                b_d     = in_data;
                state_d = S_WRITE_Y;
            end
            S_WRITE_Y: if (mem_ready) begin
                acc_d = '0;
                if (col_q == m_q - IW'(1)) begin
                    col_d = '0;
                    if (row_q == n_q - IW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + IW'(1);
                        state_d = elem_start;
                    end
                end else begin
                    col_d   = col_q + IW'(1);
                    state_d = elem_start;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_INIT;
        endcase

        opcode_d = 3'b111;
        i_d      = '0;
        j_d      = '0;
        out_d    = '0;
        fin_d    = 1'b0;
        case (state_d)
            S_GET_N:  opcode_d = 3'b000;
            S_GET_R:  opcode_d = 3'b001;
            S_GET_M:  opcode_d = 3'b110;
            S_READ_A: begin opcode_d = 3'b010; i_d = row_d; j_d = k_d;   end
            S_READ_X: begin opcode_d = 3'b011; i_d = k_d;   j_d = col_d; end
            S_READ_B: begin opcode_d = 3'b100; i_d = row_d; j_d = col_d; end
            S_WRITE_Y: begin
                opcode_d = 3'b101;
                i_d      = row_d;
                j_d      = col_d;
                out_d    = y_value(acc_d, b_d, mode_d);
            end
            S_DONE:   fin_d = 1'b1;
            default:  opcode_d = 3'b111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_INIT;
            n_q      <= '0;
            r_q      <= '0;
            m_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            mode_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            opcode   <= 3'b111;
            i        <= '0;
            j        <= '0;
            out_data <= '0;
            fin      <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            r_q      <= r_d;
            m_q      <= m_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            opcode   <= opcode_d;
            i        <= i_d;
            j        <= j_d;
            out_data <= out_d;
            fin      <= fin_d;
        end
    end
endmodule

// File: tb/tb_mo_gemm.sv
// Self-checking bench for mo_gemm: memory model, arithmetic reference model and per-cycle compare.
`timescale 1ns/1ps
module tb_mo_gemm;
    localparam int unsigned DW = 10;
    localparam int unsigned IW = 10;
    localparam int unsigned AW = 2*DW+IW;
    localparam longint MASK = (longint'(1) << AW) - 1;
    localparam int unsigned PKW = 3 + 2*IW + AW;
`ifdef MO_GEMM_SAT_EN
    localparam longint OVF_EXP = 255;
    localparam longint R0_SUB_EXP = 0;
`else
    localparam longint OVF_EXP = 144;
    localparam longint R0_SUB_EXP = 1073741819;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data;
    logic          mem_ready = 1'b1;
    logic [1:0]    mode = 2'b00;
    logic [2:0]    opcode;
    logic [IW-1:0] i, j;
    logic [AW-1:0] out_data;
    logic          fin;

    logic [DW-1:0] in_data2;
    logic          one = 1'b1;
    logic [1:0]    mode2 = 2'b00;
    logic [2:0]    opcode2;
    logic [IW-1:0] i2, j2;
    logic [7:0]    out_data2;
    logic          fin2;

    always #5 clk = ~clk;

    mo_gemm dut (
        .clk(clk), .reset(reset), .in_data(in_data), .mem_ready(mem_ready), .mode(mode),
        .opcode(opcode), .i(i), .j(j), .out_data(out_data), .fin(fin)
    );

    mo_gemm #(.DW(DW), .IW(IW), .AW(8)) dut8 (
        .clk(clk), .reset(reset), .in_data(in_data2), .mem_ready(one), .mode(mode2),
        .opcode(opcode2), .i(i2), .j(j2), .out_data(out_data2), .fin(fin2)
    );

    int unsigned mem_a [4][4];
    int unsigned mem_x [4][4];
    int unsigned mem_b [4][4];
    int unsigned dim_n, dim_r, dim_m;

    // Combinational matrix memory
    always_comb begin
        case (opcode)
            3'b000:  in_data = DW'(dim_n);
            3'b001:  in_data = DW'(dim_r);
            3'b110:  in_data = DW'(dim_m);
            3'b010:  in_data = DW'(mem_a[i[1:0]][j[1:0]]);
            3'b011:  in_data = DW'(mem_x[i[1:0]][j[1:0]]);
            3'b100:  in_data = DW'(mem_b[i[1:0]][j[1:0]]);
            default: in_data = '0;
        endcase
    end

    // 1x1x1 memory for the 8-bit accumulator instance: A=X=20, B=0
    always_comb begin
        case (opcode2)
            3'b000, 3'b001, 3'b110: in_data2 = DW'(1);
            3'b010, 3'b011:         in_data2 = DW'(20);
            default:                in_data2 = '0;
        endcase
    end

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int     row;
        int     col;
        longint val;
    } exp_t;

    exp_t   exp_q[$];
    longint got_q[$];
    exp_t   e;

    function automatic longint ref_acc(longint acc, longint p);
`ifdef MO_GEMM_SAT_EN
        return (acc + p > MASK) ? MASK : acc + p;
`else
        return (acc + p) & MASK;
`endif
    endfunction

    function automatic longint ref_y(longint acc, longint b, int md);
`ifdef MO_GEMM_SAT_EN
        if (md == 1) return (b > acc) ? 0 : acc - b;
        if (md == 2) return acc;
        return (acc + b > MASK) ? MASK : acc + b;
`else
        if (md == 1) return (acc - b) & MASK;
        if (md == 2) return acc;
        return (acc + b) & MASK;
`endif
    endfunction

    // Reference: row-major list of Y elements
    function automatic void build_expected(int nn, int rr, int mm, int md);
        exp_q.delete();
        for (int row = 0; row < nn; row++)
            for (int col = 0; col < mm; col++) begin
                longint acc = 0;
                for (int k = 0; k < rr; k++)
                    acc = ref_acc(acc, longint'(mem_a[row][k]) * longint'(mem_x[k][col]));
                exp_q.push_back('{row, col, ref_y(acc, longint'(mem_b[row][col]), md)});
            end
    endfunction

    int run_mode = 0;
    int stall_mode = 0;
    int stall_left = 0;
    bit seen_x = 0, seen_y = 0;
    int acc_cnt = 0, stall_cnt = 0, wr_cnt = 0;
    bit fin_due = 0;
    bit p_valid = 0, p_ready = 0;
    logic [2:0] p_op;
    logic [PKW-1:0] p_pk;

    // mem_ready driver: always ready, directed stalls, or random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (stall_mode)
                1: begin
                    if (stall_left > 0) begin
                        mem_ready = 1'b0;
                        stall_left--;
                    end else if (opcode == 3'b011 && !seen_x) begin
                        seen_x = 1; mem_ready = 1'b0; stall_left = 2;
                    end else if (opcode == 3'b101 && !seen_y) begin
                        seen_y = 1; mem_ready = 1'b0; stall_left = 1;
                    end else begin
                        mem_ready = 1'b1;
                    end
                end
                2:       mem_ready = ($urandom_range(0, 3) != 0);
                default: mem_ready = 1'b1;
            endcase
        end
    end

    // Per-cycle compare against the reference queue and bus rules
    always @(negedge clk) begin
        if (!reset) begin
            acc_cnt = 0; stall_cnt = 0; wr_cnt = 0; fin_due = 0; p_valid = 0;
        end else begin
            if (fin_due) begin
                check("fin_after_last_write", fin, 1);
                fin_due = 0;
            end
            if (p_valid && !p_ready && p_op != 3'b111)
                check("stall_hold", {opcode, i, j, out_data}, p_pk);
            if (run_mode == 2)
                check("no_read_b_mode10", opcode == 3'b100, 0);
            if (fin) begin
                check("done_opcode", opcode, 7);
                check("done_ij", i | j, 0);
            end
            if (opcode != 3'b111) begin
                if (mem_ready) acc_cnt++;
                else stall_cnt++;
            end
            if (opcode == 3'b101 && mem_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_row", i, e.row);
                    check("y_col", j, e.col);
                    check("y_val", out_data, e.val);
                    got_q.push_back(longint'(out_data));
                    if (exp_q.size() == 0) fin_due = 1;
                end
            end
            if (opcode2 == 3'b101)
                check("overflow_y8", out_data2, OVF_EXP);
            p_valid = 1;
            p_ready = mem_ready;
            p_op    = opcode;
            p_pk    = {opcode, i, j, out_data};
        end
    end

    function automatic void check_lit(string name, int idx, longint v);
        if (idx < got_q.size()) check(name, got_q[idx], v);
        else check(name, -1, v);
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                mem_a[a][b] = 0; mem_x[a][b] = 0; mem_b[a][b] = 0;
            end
    endtask

    task automatic set_case1();
        clear_mem();
        mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
        mem_x[0][0] = 5; mem_x[0][1] = 6; mem_x[1][0] = 7; mem_x[1][1] = 8;
        for (int a = 0; a < 2; a++)
            for (int b = 0; b < 2; b++) mem_b[a][b] = 1;
    endtask

    task automatic run_case(int nn, int rr, int mm, int md, int sm, bit abort);
        int exp_acc;
        int cnt;
        int cyc;
        dim_n = nn; dim_r = rr; dim_m = mm;
        mode = 2'(md);
        stall_mode = 0;
        run_mode = (md == 2) ? 2 : 0;
        build_expected(nn, rr, mm, md);
        got_q.delete();
        exp_acc = 3 + ((nn != 0 && mm != 0) ? nn * mm * (2 * rr + ((md == 2) ? 1 : 2)) : 0);

        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_opcode", opcode, 7);
        check("reset_ij", i | j, 0);
        check("reset_out", out_data, 0);
        check("reset_fin", fin, 0);
        seen_x = 0; seen_y = 0; stall_left = 0;
        stall_mode = sm;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("init_opcode", opcode, 7);
        @(negedge clk);
        check("get_n_opcode", opcode, 0);

        if (abort) begin
            cnt = 0;
            cyc = 0;
            while (cnt < 2 && cyc < 200) begin
                @(posedge clk); #1;
                if (opcode == 3'b010) cnt++;
                cyc++;
            end
            check("abort_reached_read_a", cnt, 2);
            reset = 1'b0;
            @(posedge clk); #1; reset = 1'b1;
            @(negedge clk);
            check("abort_opcode", opcode, 7);
            check("abort_fin", fin, 0);
            check("abort_out", out_data, 0);
            @(negedge clk);
            check("abort_get_n", opcode, 0);
        end

        cyc = 0;
        while (!fin && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("fin_within_budget", fin, 1);
        @(negedge clk);
        @(negedge clk);
        check("fin_hold", fin, 1);
        check("writes_left", exp_q.size(), 0);
        check("write_count", wr_cnt, nn * mm);
        check("accepted_cycles", acc_cnt, exp_acc);
        if (sm == 1) check("stall_cycles", stall_cnt, 5);
        stall_mode = 0;
        run_mode = 0;
    endtask

    initial begin
        set_case1();
        run_case(2, 2, 2, 0, 0, 0);
        check_lit("case1_y00", 0, 20); check_lit("case1_y01", 1, 23);
        check_lit("case1_y10", 2, 44); check_lit("case1_y11", 3, 51);

        run_case(2, 2, 2, 1, 0, 0);
        check_lit("sub_y00", 0, 18); check_lit("sub_y01", 1, 21);
        check_lit("sub_y10", 2, 42); check_lit("sub_y11", 3, 49);

        run_case(2, 2, 2, 2, 0, 0);
        check_lit("nob_y00", 0, 19); check_lit("nob_y01", 1, 22);
        check_lit("nob_y10", 2, 43); check_lit("nob_y11", 3, 50);

        run_case(2, 2, 2, 3, 0, 0);
        check_lit("mode11_y00", 0, 20); check_lit("mode11_y11", 3, 51);

        clear_mem();
        mem_a[0][0] = 1; mem_a[0][1] = 1; mem_a[0][2] = 1;
        mem_x[0][0] = 1; mem_x[0][1] = 2; mem_x[1][0] = 3;
        mem_x[1][1] = 4; mem_x[2][0] = 5; mem_x[2][1] = 6;
        run_case(1, 3, 2, 0, 0, 0);
        check_lit("rect_y00", 0, 9); check_lit("rect_y01", 1, 12);

        run_case(0, 2, 2, 0, 0, 0);
        run_case(2, 2, 0, 0, 0, 0);

        clear_mem();
        mem_b[0][0] = 5;
        run_case(1, 0, 1, 1, 0, 0);
        check_lit("r0_sub_y", 0, R0_SUB_EXP);
        run_case(1, 0, 2, 2, 0, 0);

        set_case1();
        run_case(2, 2, 2, 0, 1, 0);
        check_lit("stall_y00", 0, 20); check_lit("stall_y11", 3, 51);

        run_case(2, 2, 2, 0, 0, 1);
        check_lit("rerun_y00", 0, 20); check_lit("rerun_y01", 1, 23);
        check_lit("rerun_y10", 2, 44); check_lit("rerun_y11", 3, 51);

        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++) begin
                    mem_a[a][b] = $urandom_range(0, 1023);
                    mem_x[a][b] = $urandom_range(0, 1023);
                    mem_b[a][b] = $urandom_range(0, 1023);
                end
            run_case(int'($urandom_range(1, 4)), int'($urandom_range(0, 4)),
                     int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mo_gemm.md
Name: mo_gemm

Overview:
- Parametrised successor of the team's matrix-operation engine: computes Y = A·X ± B, with separate dimensions n×r times r×m.
- Talks to an external combinational matrix memory through an opcode/i/j request bus. Operands come back on in_data; results leave on out_data during WRITE_Y.
- Adds independent m, three compute modes, a memory-ready stall handshake and configurable data/index/accumulator widths.

Parameters:
DW, 10, element width of in_data (unsigned)
IW, 10, index/dimension width; dimensions are 0..2^IW-1
AW, 2*DW+IW, accumulator and out_data width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
in_data  in  DW  memory read data; sampled at the clock edge that ends a read cycle with mem_ready=1
mem_ready  in  1  memory accepts the current request this cycle
mode  in  2  00 A·X+B, 01 A·X−B, 10 A·X (B not read), 11 treated as 00; sampled in GET_N
opcode  out  3  000 GET_N, 001 GET_R, 110 GET_M, 010 READ_A, 011 READ_X, 100 READ_B, 101 WRITE_Y, 111 INIT/IDLE
i  out  IW  row index of current request
j  out  IW  column index of current request
out_data  out  AW  Y element; valid only while opcode=101
fin  out  1  high in DONE, held until reset

Behaviour:
- Reset: sampled at clk edge when reset=0, with the synchronous, active-low reset as decided for this block.
  - Next cycle the block is in INIT: opcode=111, i=j=0, out_data=0, fin=0.
  - Accumulator, dimension registers and counters cleared.
  - Reset mid-operation aborts immediately; no partial write follows.
- Request/stall rule:
  - opcode/i/j are driven from state registers.
  - A request completes at the edge where mem_ready=1.
  - While mem_ready=0, state, opcode, i, j, accumulator and out_data hold unchanged. This includes WRITE_Y, which is re-presented until accepted.
  - INIT and DONE ignore mem_ready.
- FSM:
  - INIT → GET_N (one cycle).
  - GET_N (latch n, mode) → GET_R (latch r) → GET_M (latch m).
  - After GET_M:
    - if n=0 or m=0 → DONE;
    - else if r=0 → READ_B (modes 00/01) or WRITE_Y (mode 10);
    - else READ_A.
  - READ_A (i=row, j=k; latch a) → READ_X (i=k, j=col).
    - On accept, acc += a·in_data; k++.
    - If k=r−1: k→0, then → READ_B (mode≠10) or WRITE_Y. Otherwise → READ_A.
  - READ_B (i=row, j=col; latch b) → WRITE_Y.
  - WRITE_Y (i=row, j=col):
    - out_data = acc+b (00/11), acc−b (01) or acc (10).
    - On accept: acc cleared; col++.
    - If col=m−1: col→0, row++. If row=n−1 → DONE, else → READ_A (or READ_B/WRITE_Y when r=0).
  - DONE: opcode=111, i=j=0, fin=1; stays until reset.
- Order and throughput:
  - Y is produced row-major.
  - Each element costs 2r+2 accepted cycles (2r+1 in mode 10).
- Arithmetic:
  - All operands unsigned.
  - Products are 2·DW bits, zero-extended to AW.
  - acc and the ±b result wrap modulo 2^AW.
- Dimensions: n/r/m are latched once per run; in_data is zero-extended to IW or truncated when DW≠IW.

Optional Feature:
MO_GEMM_SAT_EN
- Defined:
  - Accumulation clamps at 2^AW−1 and stays there.
  - acc+b clamps at 2^AW−1; acc−b clamps at 0.
- Undefined: modular wrap as above. Cycle timing is identical either way.

Test Plan:
- Full multiply-add: n=r=m=2, mode 00, A=[[1,2],[3,4]], X=[[5,6],[7,8]], B all 1, mem_ready=1.
  - Expect WRITE_Y values 20,23,44,51 at (0,0),(0,1),(1,0),(1,1).
  - Each element takes 6 cycles; fin rises the cycle after the last WRITE_Y.
- Subtract and no-B modes: same data.
  - Mode 01 → 18,21,42,49.
  - Mode 10 → 19,22,43,50, and opcode 100 never appears.
- Rectangular and degenerate dimensions:
  - n=1, r=3, m=2, A=[1,1,1], X rows [1,2],[3,4],[5,6], B=0, mode 00 → 9,12.
  - n=0 → fin immediately after GET_M with no WRITE_Y.
  - r=0, mode 01, B=[5] → out_data 2^AW−5 (0 with SAT_EN).
- Stall: case 1 with mem_ready=0 for 3 cycles in the first READ_X and 2 cycles in the first WRITE_Y.
  - opcode/i/j/out_data are frozen during the stalls.
  - Results are unchanged; total time grows by 5 cycles.
- Overflow: AW=8, n=r=m=1, A=20, X=20, B=0, mode 00.
  - Expect out_data=144 without SAT_EN and 255 with it.
- Reset mid-run: assert reset=0 during the second READ_A of case 1, then release.
  - Next cycle opcode=111, fin=0, out_data=0, then GET_N.
  - The rerun produces 20,23,44,51.
